// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC command scheduler.
//   - rtc_cmd_e     : requester opcode (TIME/PERIOD/ADJ/OFFSET)
//   - sched_state_e : scheduler FSM states
//   - payload width and the field widths/offsets inside the 86-bit payload
package rtc_pkg;

  typedef enum logic [1:0] {
    RTC_CMD_TIME   = 2'd0,
    RTC_CMD_PERIOD = 2'd1,
    RTC_CMD_ADJ    = 2'd2,
    RTC_CMD_OFFSET = 2'd3
  } rtc_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ADJ = 2'd2,
    ST_GUARD    = 2'd3
  } sched_state_e;

  localparam int RTC_PAYLOAD_W    = 86;

  // TIME = {sec[47:0], ns[37:0]}
  localparam int RTC_TIME_NS_W    = 38;
  localparam int RTC_TIME_NS_LSB  = 0;
  localparam int RTC_TIME_SEC_W   = 48;
  localparam int RTC_TIME_SEC_LSB = 38;
  // PERIOD = [39:0]
  localparam int RTC_PERIOD_W     = 40;
  localparam int RTC_PERIOD_LSB   = 0;
  // ADJ = [31:0]
  localparam int RTC_ADJ_W        = 32;
  localparam int RTC_ADJ_LSB      = 0;
  // OFFSET = {sec at [79:32], ns at [31:0]}
  localparam int RTC_OFF_NS_W     = 32;
  localparam int RTC_OFF_NS_LSB   = 0;
  localparam int RTC_OFF_SEC_W    = 48;
  localparam int RTC_OFF_SEC_LSB  = 32;

endpackage

// File: rtl/rtc_cmd_sched_rr_arbiter.sv
// Round-robin arbiter with a one-hot grant.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_req      : request vector
//   i_accept   : a grant was taken this cycle; advances the pointer
//   o_grant    : one-hot grant, lowest requesting index at or after the pointer
// After a grant to index i is accepted the pointer becomes (i+1) mod NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_accept,
  output logic [NUM_REQ-1:0] o_grant
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_cand;
  logic             w_found;

  // Scan NUM_REQ candidates starting at the pointer, wrapping around.
  always_comb begin
    o_grant = '0;
    w_idx   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && i_req[w_cand]) begin
        w_found         = 1'b1;
        o_grant[w_cand] = 1'b1;
        w_idx           = w_cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_accept) begin
      r_ptr <= (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/rtc_cmd_sched.sv
// Schedules RTC update commands from NUM_REQ requesters onto the single-load
// interface of the rtc block.
//
// Handshake: requester r transfers a command on a rising edge where
// req_valid[r] & req_ready[r] is 1. req_ready is one-hot, combinational from
// req_valid and the round-robin pointer, and only asserted in IDLE while out
// of reset. Requesters may drop valid at any time before the transfer.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid/req_ready              per-requester handshake
//   req_cmd  (2 b per requester)     opcode, see rtc_cmd_e
//   req_data (86 b per requester)    payload, field layout in rtc_pkg
//   time_ld   + ns/sec buses         TIME load strobe and payload
//   period_ld + period_in            PERIOD load strobe and payload
//   adj_ld    + adj_ld_data          ADJ load strobe and payload
//   adj_ld_done                      rtc finished the adjust
//   offset_ld + ns/sec buses         OFFSET load strobe and payload
//   busy                             FSM not in IDLE
//   err_adj_timeout                  one-cycle pulse, adj_ld_done never came
//
// Optional macro RTC_SCHED_STATS_EN adds stat_clr and five 32-bit wrapping
// event counters (stat_cnt_time/period/adj/offset/timeout).
//
// Timeline for a command accepted in cycle N: strobe in N+1, then (ADJ only)
// WAIT_ADJ, then GUARD_CYC guard cycles, then IDLE.
module rtc_cmd_sched
  import rtc_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int GUARD_CYC   = 4,
  parameter int ADJ_TIMEOUT = 1024
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [2*NUM_REQ-1:0]             req_cmd,
  input  logic [RTC_PAYLOAD_W*NUM_REQ-1:0] req_data,
  output logic                             time_ld,
  output logic [RTC_TIME_NS_W-1:0]         time_reg_ns_in,
  output logic [RTC_TIME_SEC_W-1:0]        time_reg_sec_in,
  output logic                             period_ld,
  output logic [RTC_PERIOD_W-1:0]          period_in,
  output logic                             adj_ld,
  output logic [RTC_ADJ_W-1:0]             adj_ld_data,
  input  logic                             adj_ld_done,
  output logic                             offset_ld,
  output logic [RTC_OFF_NS_W-1:0]          offset_ptp_ns_in,
  output logic [RTC_OFF_SEC_W-1:0]         offset_ptp_sec_in,
  output logic                             busy,
  output logic                             err_adj_timeout
`ifdef RTC_SCHED_STATS_EN
  ,
  input  logic                             stat_clr,
  output logic [31:0]                      stat_cnt_time,
  output logic [31:0]                      stat_cnt_period,
  output logic [31:0]                      stat_cnt_adj,
  output logic [31:0]                      stat_cnt_offset,
  output logic [31:0]                      stat_cnt_timeout
`endif
);

  sched_state_e             r_state;
  sched_state_e             w_next;
  rtc_cmd_e                 r_cmd;
  logic [NUM_REQ-1:0]       w_grant;
  logic                     w_accept;
  logic [1:0]               w_cmd;
  logic [RTC_PAYLOAD_W-1:0] w_data;
  logic [15:0]              r_to_cnt;
  logic [7:0]               r_guard_cnt;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (req_valid),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  // rst_n gating keeps req_ready low while reset is held even though the
  // state register already reads IDLE.
  assign req_ready = (r_state == ST_IDLE && rst_n) ? w_grant : '0;
  assign w_accept  = |(req_valid & req_ready);
  assign busy      = (r_state != ST_IDLE);

  // Select the granted requester's opcode and payload (grant is one-hot).
  always_comb begin
    w_cmd  = '0;
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_cmd  = req_cmd[2*i +: 2];
        w_data = req_data[RTC_PAYLOAD_W*i +: RTC_PAYLOAD_W];
      end
    end
  end

  always_comb begin
    w_next          = r_state;
    time_ld         = 1'b0;
    period_ld       = 1'b0;
    adj_ld          = 1'b0;
    offset_ld       = 1'b0;
    err_adj_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        case (r_cmd)
          RTC_CMD_TIME:   time_ld   = 1'b1;
          RTC_CMD_PERIOD: period_ld = 1'b1;
          RTC_CMD_ADJ:    adj_ld    = 1'b1;
          RTC_CMD_OFFSET: offset_ld = 1'b1;
          default:        time_ld   = 1'b0;
        endcase
        w_next = (r_cmd == RTC_CMD_ADJ) ? ST_WAIT_ADJ : ST_GUARD;
      end
      ST_WAIT_ADJ: begin
        // A done arriving on the last allowed cycle wins over the timeout.
        if (adj_ld_done) begin
          w_next = ST_GUARD;
        end else if (r_to_cnt >= 16'(ADJ_TIMEOUT - 1)) begin
          err_adj_timeout = 1'b1;
          w_next          = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (r_guard_cnt == 8'(GUARD_CYC - 1)) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= ST_IDLE;
      r_cmd             <= RTC_CMD_TIME;
      r_to_cnt          <= '0;
      r_guard_cnt       <= '0;
      time_reg_ns_in    <= '0;
      time_reg_sec_in   <= '0;
      period_in         <= '0;
      adj_ld_data       <= '0;
      offset_ptp_ns_in  <= '0;
      offset_ptp_sec_in <= '0;
    end else begin
      r_state     <= w_next;
      // Counters run only in their own state and restart from 0 on entry.
      r_to_cnt    <= (r_state != ST_WAIT_ADJ) ? '0 :
                     (r_to_cnt == 16'hFFFF)   ? r_to_cnt : r_to_cnt + 16'd1;
      r_guard_cnt <= (r_state == ST_GUARD) ? r_guard_cnt + 8'd1 : '0;
      // Only the accepted command's bus is loaded; the others hold.
      if (w_accept) begin
        r_cmd <= rtc_cmd_e'(w_cmd);
        case (rtc_cmd_e'(w_cmd))
          RTC_CMD_TIME: begin
            time_reg_ns_in  <= w_data[RTC_TIME_NS_LSB +: RTC_TIME_NS_W];
            time_reg_sec_in <= w_data[RTC_TIME_SEC_LSB +: RTC_TIME_SEC_W];
          end
          RTC_CMD_PERIOD: period_in   <= w_data[RTC_PERIOD_LSB +: RTC_PERIOD_W];
          RTC_CMD_ADJ:    adj_ld_data <= w_data[RTC_ADJ_LSB +: RTC_ADJ_W];
          RTC_CMD_OFFSET: begin
            offset_ptp_ns_in  <= w_data[RTC_OFF_NS_LSB +: RTC_OFF_NS_W];
            offset_ptp_sec_in <= w_data[RTC_OFF_SEC_LSB +: RTC_OFF_SEC_W];
          end
          default: r_cmd <= rtc_cmd_e'(w_cmd);
        endcase
      end
    end
  end

`ifdef RTC_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cnt_time    <= '0;
      stat_cnt_period  <= '0;
      stat_cnt_adj     <= '0;
      stat_cnt_offset  <= '0;
      stat_cnt_timeout <= '0;
    end else if (stat_clr) begin
      stat_cnt_time    <= '0;
      stat_cnt_period  <= '0;
      stat_cnt_adj     <= '0;
      stat_cnt_offset  <= '0;
      stat_cnt_timeout <= '0;
    end else begin
      stat_cnt_time    <= stat_cnt_time    + 32'(time_ld);
      stat_cnt_period  <= stat_cnt_period  + 32'(period_ld);
      stat_cnt_adj     <= stat_cnt_adj     + 32'(adj_ld);
      stat_cnt_offset  <= stat_cnt_offset  + 32'(offset_ld);
      stat_cnt_timeout <= stat_cnt_timeout + 32'(err_adj_timeout);
    end
  end
`endif

endmodule

// File: tb/tb_rtc_cmd_sched.sv
// Bench for rtc_cmd_sched: directed scenarios plus random traffic, checked
// against a timeline model of the scheduler and a scoreboard of strobes.
module tb_rtc_cmd_sched;
  import rtc_pkg::*;

  localparam int NR = 3;
  localparam int GC = 3;
  localparam int AT = 200;
  localparam int PW = 86;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_ready;
  logic [2*NR-1:0]  req_cmd   = '0;
  logic [PW*NR-1:0] req_data  = '0;
  logic             time_ld, period_ld, adj_ld, offset_ld;
  logic [37:0]      time_reg_ns_in;
  logic [47:0]      time_reg_sec_in;
  logic [39:0]      period_in;
  logic [31:0]      adj_ld_data;
  logic             adj_ld_done = 1'b0;
  logic [31:0]      offset_ptp_ns_in;
  logic [47:0]      offset_ptp_sec_in;
  logic             busy, err_adj_timeout;
`ifdef RTC_SCHED_STATS_EN
  logic             stat_clr = 1'b0;
  logic [31:0]      stat_cnt_time, stat_cnt_period, stat_cnt_adj;
  logic [31:0]      stat_cnt_offset, stat_cnt_timeout;
`endif

  rtc_cmd_sched #(.NUM_REQ(NR), .GUARD_CYC(GC), .ADJ_TIMEOUT(AT)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_cmd           (req_cmd),
    .req_data          (req_data),
    .time_ld           (time_ld),
    .time_reg_ns_in    (time_reg_ns_in),
    .time_reg_sec_in   (time_reg_sec_in),
    .period_ld         (period_ld),
    .period_in         (period_in),
    .adj_ld            (adj_ld),
    .adj_ld_data       (adj_ld_data),
    .adj_ld_done       (adj_ld_done),
    .offset_ld         (offset_ld),
    .offset_ptp_ns_in  (offset_ptp_ns_in),
    .offset_ptp_sec_in (offset_ptp_sec_in),
    .busy              (busy),
    .err_adj_timeout   (err_adj_timeout)
`ifdef RTC_SCHED_STATS_EN
    ,
    .stat_clr          (stat_clr),
    .stat_cnt_time     (stat_cnt_time),
    .stat_cnt_period   (stat_cnt_period),
    .stat_cnt_adj      (stat_cnt_adj),
    .stat_cnt_offset   (stat_cnt_offset),
    .stat_cnt_timeout  (stat_cnt_timeout)
`endif
  );

  // ---------------- check bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string name,
                     input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model (timeline level) ----------------
  typedef struct {
    int             cyc;
    logic [1:0]     cmd;
    logic [PW-1:0]  data;
  } exp_t;

  exp_t exp_q[$];   // expected strobes: cycle, opcode, payload
  int   err_q[$];   // expected timeout pulse cycles

  int          m_ptr   = 0;
  int          m_free  = 0;   // first cycle the scheduler is idle again
  bit          m_wait  = 0;   // waiting for adj_ld_done
  int          m_wstart = 0;  // cycle of the ADJ strobe
  int          m_win;
  bit          m_busy;
  logic [NR-1:0] m_rdy;
  logic [1:0]  m_cmd;

  always begin
    @(negedge clk);
    if (!rst_n) begin
      m_ptr  = 0;
      m_free = 0;
      m_wait = 0;
      exp_q.delete();
      err_q.delete();
      chk(req_ready == '0 && busy == 1'b0, "reset_quiet", {req_ready, busy}, 0);
    end else begin
      m_busy = m_wait || (cyc < m_free);
      chk(busy == m_busy, "busy", busy, m_busy);
      // Winner: lowest valid index at or after the pointer, else wrap.
      m_win = -1;
      if (!m_busy) begin
        for (int i = m_ptr; i < NR; i++) if (m_win < 0 && req_valid[i]) m_win = i;
        for (int i = 0; i < m_ptr; i++) if (m_win < 0 && req_valid[i]) m_win = i;
      end
      m_rdy = '0;
      if (m_win >= 0) m_rdy[m_win] = 1'b1;
      chk(req_ready == m_rdy, "req_ready", req_ready, m_rdy);
      if (m_wait && cyc > m_wstart) begin
        if (adj_ld_done) begin
          m_wait = 0;
          m_free = cyc + 1 + GC;
        end else if (cyc - m_wstart == AT) begin
          err_q.push_back(cyc);
          m_wait = 0;
          m_free = cyc + 1 + GC;
        end
      end
      if (m_win >= 0) begin
        m_cmd = req_cmd[2*m_win +: 2];
        exp_q.push_back('{cyc: cyc + 1, cmd: m_cmd, data: req_data[PW*m_win +: PW]});
        m_ptr = (m_win + 1) % NR;
        if (m_cmd == 2'd2) begin
          m_wait   = 1;
          m_wstart = cyc + 1;
        end else begin
          m_free = cyc + 2 + GC;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [37:0] e_tns;  logic [47:0] e_tsec; logic [39:0] e_per;
  logic [31:0] e_adj;  logic [31:0] e_ons;  logic [47:0] e_osec;
  logic [3:0]  mon_ld, mon_exp_ld;
  exp_t        mon_e;

  always begin
    @(negedge clk);
    #1;
    mon_ld = {time_ld, period_ld, adj_ld, offset_ld};
    if (!rst_n) begin
      e_tns = '0; e_tsec = '0; e_per = '0; e_adj = '0; e_ons = '0; e_osec = '0;
      chk(mon_ld == 4'b0 && !err_adj_timeout, "reset_strobes", {mon_ld, err_adj_timeout}, 0);
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL strobe_missing cycle=%0d got=none expected=cmd %0d at cycle %0d",
                 cyc, exp_q[0].cmd, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (mon_ld != 4'b0) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_strobe", mon_ld, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk(mon_e.cyc == cyc, "strobe_cycle", cyc, mon_e.cyc);
          mon_exp_ld = 4'b1000 >> mon_e.cmd;
          chk(mon_ld == mon_exp_ld, "strobe_type", mon_ld, mon_exp_ld);
          case (mon_e.cmd)
            2'd0: begin e_tns = mon_e.data[37:0]; e_tsec = mon_e.data[85:38]; end
            2'd1: e_per = mon_e.data[39:0];
            2'd2: e_adj = mon_e.data[31:0];
            default: begin e_ons = mon_e.data[31:0]; e_osec = mon_e.data[79:32]; end
          endcase
        end
      end
      chk({time_reg_ns_in, time_reg_sec_in, period_in} == {e_tns, e_tsec, e_per},
          "bus_time_period", {time_reg_ns_in, time_reg_sec_in, period_in}, {e_tns, e_tsec, e_per});
      chk({adj_ld_data, offset_ptp_ns_in, offset_ptp_sec_in} == {e_adj, e_ons, e_osec},
          "bus_adj_offset", {adj_ld_data, offset_ptp_ns_in, offset_ptp_sec_in}, {e_adj, e_ons, e_osec});
      while (err_q.size() > 0 && err_q[0] < cyc) begin
        checks++; errors++;
        $display("FAIL timeout_missing cycle=%0d got=none expected=pulse at cycle %0d", cyc, err_q[0]);
        void'(err_q.pop_front());
      end
      if (err_adj_timeout) begin
        if (err_q.size() == 0) chk(1'b0, "unexpected_timeout", 1, 0);
        else chk(err_q.pop_front() == cyc, "timeout_cycle", cyc, cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [PW-1:0] rand_payload();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[PW-1:0];
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raise valid on requester r and hold until the transfer; returns the
  // accept cycle, -1 if it never came.
  task automatic send(input int r, input logic [1:0] cmd, input logic [PW-1:0] data,
                      output int acc);
    bit done;
    done = 0;
    acc  = -1;
    req_valid[r]        = 1'b1;
    req_cmd[2*r +: 2]   = cmd;
    req_data[PW*r +: PW] = data;
    for (int n = 0; n < 2*AT + 50 && !done; n++) begin
      @(negedge clk);
      if (req_ready[r]) begin
        acc  = cyc;
        done = 1;
        @(posedge clk);
        #1;
        req_valid[r] = 1'b0;
      end
    end
    if (!done) begin
      req_valid[r] = 1'b0;
      chk(1'b0, "send_timeout", r, cmd);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int a0, a1;

  initial begin
    step(3);
    chk({time_ld, period_ld, adj_ld, offset_ld, busy, err_adj_timeout, req_ready} == '0,
        "reset_outputs", {time_ld, period_ld, adj_ld, offset_ld, busy, err_adj_timeout, req_ready}, 0);
    chk({time_reg_ns_in, time_reg_sec_in, period_in, adj_ld_data} == '0, "reset_payload",
        {time_reg_ns_in, time_reg_sec_in, period_in, adj_ld_data}, 0);
    rst_n = 1'b1;
    step(2);

    // Single PERIOD, then an immediate follow-up: regrant exactly 2+GUARD later.
    send(0, 2'd1, 86'h08_0000_0000, a0);
    send(0, 2'd0, {48'h0000_1234_5678, 38'h3B_9AC9_FF}, a1);
    chk(a1 - a0 == 2 + GC, "regrant_spacing", a1 - a0, 2 + GC);
    step(GC + 3);

    // Two requesters continuously valid: TIME and OFFSET alternate.
    req_cmd[1:0] = 2'd0;
    req_data[PW*0 +: PW] = {48'h0000_0000_00AA, 38'd123456789};
    req_cmd[3:2] = 2'd3;
    req_data[PW*1 +: PW] = {6'b0, 48'h8000_0000_0000, 32'd999999999};
    req_valid = 3'b011;
    step(4 * (2 + GC) + 1);
    req_valid = '0;
    step(GC + 3);

    // ADJ acknowledged 10 cycles after the strobe.
    send(0, 2'd2, 86'd5000, a0);
    step(10);
    adj_ld_done = 1'b1;
    step(1);
    adj_ld_done = 1'b0;
    step(GC + 3);

    // ADJ never acknowledged: timeout pulse, then guard.
    send(1, 2'd2, 86'h1234, a0);
    step(AT + GC + 5);

    // Reset in the middle of WAIT_ADJ.
    send(2, 2'd2, 86'h55, a0);
    step(5);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    req_cmd[1:0] = 2'd1;
    req_data[PW*0 +: PW] = 86'hAB_CDEF_0123;
    req_cmd[3:2] = 2'd0;
    req_valid = 3'b011;
    #1;
    chk({time_ld, period_ld, adj_ld, offset_ld, busy, req_ready} == '0, "reset_abort",
        {time_ld, period_ld, adj_ld, offset_ld, busy, req_ready}, 0);
    step(2);
    rst_n = 1'b1;
    @(negedge clk);
    chk(req_ready == 3'b001, "post_reset_grant", req_ready, 3'b001);
    @(posedge clk);
    #1;
    req_valid = '0;
    step(GC + 4);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      for (int r = 0; r < NR; r++) begin
        req_valid[r]         = 1'($urandom_range(0, 1));
        req_cmd[2*r +: 2]    = 2'($urandom_range(0, 3));
        req_data[PW*r +: PW] = rand_payload();
      end
      adj_ld_done = ($urandom_range(0, 5) == 0);
      step(1);
    end
    req_valid   = '0;
    adj_ld_done = 1'b0;
    step(AT + GC + 10);

`ifdef RTC_SCHED_STATS_EN
    stat_clr = 1'b1;
    step(1);
    stat_clr = 1'b0;
    for (int k = 0; k < 3; k++) send(0, 2'd0, rand_payload(), a0);
    send(1, 2'd2, 86'd77, a0);
    step(3);
    adj_ld_done = 1'b1;
    step(1);
    adj_ld_done = 1'b0;
    step(GC + 3);
    send(1, 2'd2, 86'd88, a0);
    step(AT + GC + 5);
    chk({stat_cnt_time, stat_cnt_period, stat_cnt_adj, stat_cnt_offset} == {32'd3, 32'd0, 32'd2, 32'd0},
        "stat_counts", {stat_cnt_time, stat_cnt_period, stat_cnt_adj, stat_cnt_offset},
        {32'd3, 32'd0, 32'd2, 32'd0});
    chk(stat_cnt_timeout == 32'd1, "stat_timeout", stat_cnt_timeout, 1);
    stat_clr = 1'b1;
    step(1);
    stat_clr = 1'b0;
    chk({stat_cnt_time, stat_cnt_period, stat_cnt_adj, stat_cnt_offset, stat_cnt_timeout} == '0,
        "stat_clear", {stat_cnt_time, stat_cnt_period, stat_cnt_adj, stat_cnt_offset, stat_cnt_timeout}, 0);
`endif

    step(5);
    chk(exp_q.size() == 0, "exp_q_drained", exp_q.size(), 0);
    chk(err_q.size() == 0, "err_q_drained", err_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
